ccu_snoop_responder: RTL and testbench

Cache-side endpoint of the ACE snoop interface driven by the CCU. It accepts one AC snoop request at a time and looks up the local dcache through a simple tag/data port. It applies the required state change, returns the CR response, and then serializes any line data onto CD. It sits between a coherent L1 (one per CCU slave port) and the CCU snoop master.

---
 rtl/ccu_pkg.sv | 75 +++++++
 rtl/ccu_line_serializer.sv | 49 ++++
 rtl/ccu_snoop_responder.sv | 132 +++++++++++++
 tb/tb_ccu_snoop_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_pkg.sv
// rtl/ccu_pkg.sv - snoop codes, CR bit positions, update ops and the snoop decode function
package ccu_pkg;

  localparam logic [3:0] SNP_READ_ONCE             = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED           = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN            = 4'b0010;
  localparam logic [3:0] SNP_READ_NOT_SHARED_DIRTY = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE           = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED          = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID         = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID          = 4'b1101;

  localparam int CR_DT  = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD  = 2;
  localparam int CR_IS  = 3;
  localparam int CR_WU  = 4;

  typedef enum logic [1:0] {
    UPD_NONE              = 2'd0,
    UPD_INVALIDATE        = 2'd1,
    UPD_MAKE_SHARED       = 2'd2,
    UPD_MAKE_SHARED_CLEAN = 2'd3
  } upd_op_e;

  typedef struct packed {
    logic [4:0] resp;
    upd_op_e    op;
    logic       need_upd;
  } snoop_rsp_t;

  // A miss on a known snoop answers all-zero; unknown codes report Error whatever the lookup says.
  function automatic snoop_rsp_t ccu_snoop_decode(input logic [3:0] snoop, input logic hit,
                                                  input logic dirty, input logic uniq);
    snoop_rsp_t r;
    r.resp     = '0;
    r.op       = UPD_NONE;
    r.need_upd = 1'b0;
    case (snoop)
      SNP_READ_ONCE: if (hit) begin
        r.resp[CR_DT] = 1'b1;  r.resp[CR_IS] = 1'b1;  r.resp[CR_WU] = uniq;
      end
      SNP_READ_SHARED, SNP_READ_NOT_SHARED_DIRTY: if (hit) begin
        r.resp[CR_DT] = 1'b1;  r.resp[CR_PD] = dirty;
        r.resp[CR_IS] = 1'b1;  r.resp[CR_WU] = uniq;
        r.op = UPD_MAKE_SHARED_CLEAN;
      end
      SNP_READ_CLEAN: if (hit) begin
        r.resp[CR_DT] = 1'b1;  r.resp[CR_IS] = 1'b1;  r.resp[CR_WU] = uniq;
        r.op = UPD_MAKE_SHARED;
      end
      SNP_READ_UNIQUE: if (hit) begin
        r.resp[CR_DT] = 1'b1;  r.resp[CR_PD] = dirty;  r.resp[CR_WU] = uniq;
        r.op = UPD_INVALIDATE;
      end
      SNP_CLEAN_INVALID: if (hit) begin
        r.resp[CR_DT] = dirty; r.resp[CR_PD] = dirty;  r.resp[CR_WU] = uniq;
        r.op = UPD_INVALIDATE;
      end
      SNP_CLEAN_SHARED: if (hit) begin
        r.resp[CR_DT] = dirty; r.resp[CR_PD] = dirty;
        r.resp[CR_IS] = 1'b1;  r.resp[CR_WU] = uniq;
        r.op = UPD_MAKE_SHARED_CLEAN;
      end
      SNP_MAKE_INVALID: if (hit) begin
        r.resp[CR_WU] = uniq;
        r.op = UPD_INVALIDATE;
      end
      default: r.resp[CR_ERR] = 1'b1;
    endcase
    r.need_upd = (r.op != UPD_NONE);
    return r;
  endfunction

endpackage

// File: rtl/ccu_line_serializer.sv
// rtl/ccu_line_serializer.sv - splits a captured cache line into a beat stream, lowest beat first
module ccu_line_serializer #(
  parameter int DataWidth = 64,
  parameter int LineWidth = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LineWidth-1:0] line,
  input  logic                 start,
  output logic                 tvalid,
  input  logic                 tready,
  output logic [DataWidth-1:0] tdata,
  output logic                 tlast
);
  localparam int NumBeats = LineWidth / DataWidth;
  localparam int CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

  logic [LineWidth-1:0] line_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (load) line_q <= line;
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q && tready) begin
        if (cnt_q == LastBeat) begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign tvalid = busy_q;
  assign tlast  = busy_q && (cnt_q == LastBeat);
  assign tdata  = line_q[int'(cnt_q) * DataWidth +: DataWidth];

endmodule

// File: rtl/ccu_snoop_responder.sv
// rtl/ccu_snoop_responder.sv - ACE snoop endpoint: AC accept, dcache lookup/update, CR response, CD data
module ccu_snoop_responder
  import ccu_pkg::*;
#(
  parameter int AxiAddrWidth    = 64,
  parameter int AxiDataWidth    = 64,
  parameter int DcacheLineWidth = 512
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AxiAddrWidth-1:0]    ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  input  logic [2:0]                 ac_prot_i,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [4:0]                 cr_resp_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [AxiDataWidth-1:0]    cd_data_o,
  output logic                       cd_last_o,
  output logic                       lkp_valid_o,
  input  logic                       lkp_ready_i,
  output logic [AxiAddrWidth-1:0]    lkp_addr_o,
  input  logic                       lkp_rsp_valid_i,
  input  logic                       lkp_hit_i,
  input  logic                       lkp_dirty_i,
  input  logic                       lkp_unique_i,
  input  logic [DcacheLineWidth-1:0] lkp_data_i,
  output logic                       upd_valid_o,
  input  logic                       upd_ready_i,
  output logic [AxiAddrWidth-1:0]    upd_addr_o,
  output logic [1:0]                 upd_op_o
);
  localparam int OffW = $clog2(DcacheLineWidth / 8);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_UPDATE, S_RESP, S_DATA} state_e;

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [3:0]              snoop_q;
  snoop_rsp_t              rsp_q, dec;
  logic                    ac_hs, rsp_take, ser_start;
  logic                    unused_bits;

  assign unused_bits = ^{ac_prot_i, ac_addr_i[OffW-1:0]};
  assign dec = ccu_snoop_decode(snoop_q, lkp_hit_i, lkp_dirty_i, lkp_unique_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      snoop_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ac_hs) begin
        addr_q  <= {ac_addr_i[AxiAddrWidth-1:OffW], {OffW{1'b0}}};
        snoop_q <= ac_snoop_i;
      end
      if (rsp_take) rsp_q <= dec;
    end
  end

  always_comb begin
    state_d     = state_q;
    ac_ready_o  = 1'b0;
    lkp_valid_o = 1'b0;
    upd_valid_o = 1'b0;
    cr_valid_o  = 1'b0;
    ac_hs       = 1'b0;
    rsp_take    = 1'b0;
    ser_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ac_ready_o = 1'b1;
        if (ac_valid_i) begin
          ac_hs   = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        lkp_valid_o = 1'b1;
        if (lkp_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lkp_rsp_valid_i) begin
          rsp_take = 1'b1;
          state_d  = dec.need_upd ? S_UPDATE : S_RESP;
        end
      end
      S_UPDATE: begin
        upd_valid_o = 1'b1;
        if (upd_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        cr_valid_o = 1'b1;
        if (cr_ready_i) begin
          ser_start = rsp_q.resp[CR_DT];
          state_d   = rsp_q.resp[CR_DT] ? S_DATA : S_IDLE;
        end
      end
      S_DATA: begin
        if (cd_valid_o && cd_ready_i && cd_last_o) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lkp_addr_o = addr_q;
  assign upd_addr_o = addr_q;
  assign upd_op_o   = rsp_q.op;
  assign cr_resp_o  = rsp_q.resp;

  // Line is captured with the lookup result so CD replays exactly what the cache returned.
  ccu_line_serializer #(
    .DataWidth (AxiDataWidth),
    .LineWidth (DcacheLineWidth)
  ) u_serializer (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .load   (rsp_take),
    .line   (lkp_data_i),
    .start  (ser_start),
    .tvalid (cd_valid_o),
    .tready (cd_ready_i),
    .tdata  (cd_data_o),
    .tlast  (cd_last_o)
  );

endmodule

// File: tb/tb_ccu_snoop_responder.sv
// tb/tb_ccu_snoop_responder.sv - randomized self-checking bench for ccu_snoop_responder
module tb_ccu_snoop_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ac_valid_i, ac_ready_o;
  logic [63:0]  ac_addr_i;
  logic [3:0]   ac_snoop_i;
  logic [2:0]   ac_prot_i;
  logic         cr_valid_o, cr_ready_i;
  logic [4:0]   cr_resp_o;
  logic         cd_valid_o, cd_ready_i, cd_last_o;
  logic [63:0]  cd_data_o;
  logic         lkp_valid_o, lkp_ready_i, lkp_rsp_valid_i, lkp_hit_i, lkp_dirty_i, lkp_unique_i;
  logic [63:0]  lkp_addr_o;
  logic [511:0] lkp_data_i;
  logic         upd_valid_o, upd_ready_i;
  logic [63:0]  upd_addr_o;
  logic [1:0]   upd_op_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] beats_q[$];
  logic        lasts_q[$];

  always #5 clk = ~clk;

  ccu_snoop_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .lkp_valid_o(lkp_valid_o), .lkp_ready_i(lkp_ready_i), .lkp_addr_o(lkp_addr_o),
    .lkp_rsp_valid_i(lkp_rsp_valid_i), .lkp_hit_i(lkp_hit_i), .lkp_dirty_i(lkp_dirty_i),
    .lkp_unique_i(lkp_unique_i), .lkp_data_i(lkp_data_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_addr_o(upd_addr_o), .upd_op_o(upd_op_o)
  );

  // Reference: classify the snoop by which outcome sets it belongs to.
  function automatic void model(input logic [3:0] s, input logic h, input logic d, input logic u,
                                output logic [4:0] resp, output logic [1:0] op);
    logic known, dt, pd, is_sh;
    known = (s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13});
    resp = 5'd0;
    op   = 2'd0;
    if (!known) begin
      resp = 5'b00010;
    end else if (h) begin
      dt    = (s inside {4'd8, 4'd9}) ? d : (s != 4'd13);
      pd    = d && (s inside {4'd1, 4'd3, 4'd7, 4'd8, 4'd9});
      is_sh = (s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8});
      resp  = {u, is_sh, pd, 1'b0, dt};
      if (s inside {4'd1, 4'd3, 4'd8}) op = 2'd3;
      else if (s == 4'd2) op = 2'd2;
      else if (s inside {4'd7, 4'd9, 4'd13}) op = 2'd1;
    end
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Plays the cache and CCU sides of one snoop; decisions are made on the falling edge.
  task automatic run_snoop(input logic [3:0] snoop, input logic [63:0] addr, input logic h,
                           input logic d, input logic u, input logic [511:0] line, input int bp,
                           input int stop_beats, output logic got_upd, output logic [1:0] op,
                           output logic [4:0] resp, output logic [63:0] lkp_a, output logic [63:0] upd_a,
                           output int serr, output int oerr, output logic acr);
    logic done, stopped, ac_sent, rsp_next, cr_seen;
    logic lkp_hold, upd_hold, cr_hold, cd_hold, cd_l_h;
    logic [63:0] lkp_a_h, upd_a_h, cd_d_h;
    logic [1:0] upd_op_h;
    logic [4:0] cr_h;
    int cyc, lkp_w, upd_w, cr_w, cd_w;
    got_upd = 0; op = 0; resp = 0; lkp_a = 0; upd_a = 0; serr = 0; oerr = 0; acr = 0;
    done = 0; stopped = 0; ac_sent = 0; rsp_next = 0; cr_seen = 0;
    lkp_hold = 0; upd_hold = 0; cr_hold = 0; cd_hold = 0; cd_l_h = 0;
    lkp_a_h = 0; upd_a_h = 0; cd_d_h = 0; upd_op_h = 0; cr_h = 0;
    lkp_w = 0; upd_w = 0; cr_w = 0; cd_w = 0; cyc = 0;
    beats_q.delete(); lasts_q.delete();
    @(negedge clk);
    ac_valid_i = 1; ac_addr_i = addr; ac_snoop_i = snoop; ac_prot_i = 3'($urandom);
    lkp_hit_i = h; lkp_dirty_i = d; lkp_unique_i = u; lkp_data_i = line;
    while (!done && !stopped && cyc < 300) begin
      if (ac_sent) ac_valid_i = 0;
      else if (ac_valid_i && ac_ready_o) ac_sent = 1;
      lkp_rsp_valid_i = rsp_next;
      rsp_next = 0;
      if (lkp_valid_o) begin
        if (lkp_hold && lkp_addr_o !== lkp_a_h) serr++;
        lkp_a = lkp_addr_o;
        if (lkp_w < bp) begin lkp_ready_i = 0; lkp_w++; lkp_hold = 1; lkp_a_h = lkp_addr_o; end
        else begin lkp_ready_i = 1; rsp_next = 1; lkp_hold = 0; end
      end else begin
        if (lkp_hold) serr++;
        lkp_hold = 0; lkp_ready_i = 1'($urandom);
      end
      if (upd_valid_o) begin
        if (upd_hold && {upd_addr_o, upd_op_o} !== {upd_a_h, upd_op_h}) serr++;
        if (cr_seen) oerr++;
        if (upd_w < bp) begin
          upd_ready_i = 0; upd_w++; upd_hold = 1; upd_a_h = upd_addr_o; upd_op_h = upd_op_o;
        end else begin
          upd_ready_i = 1; upd_hold = 0; got_upd = 1; op = upd_op_o; upd_a = upd_addr_o;
        end
      end else begin
        if (upd_hold) serr++;
        upd_hold = 0; upd_ready_i = 0;
      end
      if (cr_valid_o) begin
        cr_seen = 1;
        if (cr_hold && cr_resp_o !== cr_h) serr++;
        if (cr_w < bp) begin cr_ready_i = 0; cr_w++; cr_hold = 1; cr_h = cr_resp_o; end
        else begin
          cr_ready_i = 1; cr_hold = 0; resp = cr_resp_o;
          if (!cr_resp_o[0]) done = 1;
        end
      end else begin
        if (cr_hold) serr++;
        cr_hold = 0; cr_ready_i = 0;
      end
      if (cd_valid_o) begin
        if (cd_hold && {cd_data_o, cd_last_o} !== {cd_d_h, cd_l_h}) serr++;
        if (stop_beats >= 0 && beats_q.size() == stop_beats) begin
          cd_ready_i = 0; stopped = 1;
        end else if ((beats_q.size() == 0 && cd_w < bp) ||
                     (beats_q.size() != 0 && $urandom_range(0, 3) == 0)) begin
          cd_ready_i = 0; cd_w++; cd_hold = 1; cd_d_h = cd_data_o; cd_l_h = cd_last_o;
        end else begin
          cd_ready_i = 1; cd_hold = 0;
          beats_q.push_back(cd_data_o); lasts_q.push_back(cd_last_o);
          if (cd_last_o || beats_q.size() >= 64) done = 1;
        end
      end else begin
        if (cd_hold) serr++;
        cd_hold = 0; cd_ready_i = 0;
      end
      cyc++;
      if (!done && !stopped) @(negedge clk);
    end
    n_tests++;
    if (!done && !stopped) begin
      n_fail++;
      $display("FAIL timeout snoop=%b after %0d cycles, required completion", snoop, cyc);
    end
    if (!stopped) begin
      @(negedge clk);
      lkp_ready_i = 0; upd_ready_i = 0; cr_ready_i = 0; cd_ready_i = 0; lkp_rsp_valid_i = 0;
      ac_valid_i = 0;
      acr = ac_ready_o;
    end
  endtask

  task automatic test_reset;
    n_tests++;
    if ({ac_ready_o, lkp_valid_o, upd_valid_o, cr_valid_o, cd_valid_o, cd_last_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags got %b required 100000",
               {ac_ready_o, lkp_valid_o, upd_valid_o, cr_valid_o, cd_valid_o, cd_last_o});
    end
    n_tests++;
    if ({cr_resp_o, upd_op_o} !== 7'd0) begin
      n_fail++; $display("FAIL reset_resp_op got %b required 0", {cr_resp_o, upd_op_o});
    end
    n_tests++;
    if ({lkp_addr_o, upd_addr_o, cd_data_o} !== 192'd0) begin
      n_fail++; $display("FAIL reset_payload got %h %h %h required 0", lkp_addr_o, upd_addr_o, cd_data_o);
    end
  endtask

  task automatic test_read_shared;
    logic [511:0] line; logic [63:0] addr, la, ua; logic gu, acr; logic [1:0] op; logic [4:0] rsp;
    int se, oe, bad;
    line = rand_line(); addr = {$urandom, $urandom};
    run_snoop(4'b0001, addr, 1, 1, 1, line, 0, -1, gu, op, rsp, la, ua, se, oe, acr);
    n_tests++;
    if ({gu, op} !== 3'b111) begin n_fail++; $display("FAIL rs_upd got %b required 111", {gu, op}); end
    n_tests++;
    if (rsp !== 5'b11101) begin n_fail++; $display("FAIL rs_resp got %b required 11101", rsp); end
    n_tests++;
    if (la !== {addr[63:6], 6'd0} || ua !== {addr[63:6], 6'd0}) begin
      n_fail++; $display("FAIL rs_addr got %h/%h required %h", la, ua, {addr[63:6], 6'd0});
    end
    bad = 0;
    for (int i = 0; i < beats_q.size(); i++)
      if (beats_q[i] !== line[i*64 +: 64] || lasts_q[i] !== (i == 7)) bad++;
    n_tests++;
    if (beats_q.size() != 8 || bad != 0) begin
      n_fail++; $display("FAIL rs_beats got %0d beats (%0d wrong) required 8 (0 wrong)", beats_q.size(), bad);
    end
    n_tests++;
    if (se + oe != 0) begin n_fail++; $display("FAIL rs_protocol got %0d errors required 0", se + oe); end
  endtask

  task automatic test_read_unique_miss;
    logic [63:0] la, ua; logic gu, acr; logic [1:0] op; logic [4:0] rsp; int se, oe;
    run_snoop(4'b0111, {$urandom, $urandom}, 0, 1, 1, rand_line(), 0, -1, gu, op, rsp, la, ua, se, oe, acr);
    n_tests++;
    if ({gu, rsp, 7'(beats_q.size())} !== 13'd0) begin
      n_fail++; $display("FAIL ru_miss got upd=%b resp=%b beats=%0d required 0/0/0", gu, rsp, beats_q.size());
    end
    n_tests++;
    if (acr !== 1'b1) begin n_fail++; $display("FAIL ru_ac_ready got %b required 1", acr); end
  endtask

  task automatic test_clean_invalid;
    logic [63:0] la, ua; logic gu, acr; logic [1:0] op; logic [4:0] rsp; int se, oe;
    run_snoop(4'b1001, {$urandom, $urandom}, 1, 0, 0, rand_line(), 0, -1, gu, op, rsp, la, ua, se, oe, acr);
    n_tests++;
    if ({gu, op} !== 3'b101) begin n_fail++; $display("FAIL ci_upd got %b required 101", {gu, op}); end
    n_tests++;
    if (rsp !== 5'b00000 || beats_q.size() != 0) begin
      n_fail++; $display("FAIL ci_resp got %b beats=%0d required 00000 beats=0", rsp, beats_q.size());
    end
  endtask

  task automatic test_error_snoop;
    logic [63:0] la, ua; logic gu, acr; logic [1:0] op; logic [4:0] rsp; int se, oe;
    run_snoop(4'b0101, {$urandom, $urandom}, 1, 1, 1, rand_line(), 0, -1, gu, op, rsp, la, ua, se, oe, acr);
    n_tests++;
    if (gu !== 1'b0 || rsp !== 5'b00010 || beats_q.size() != 0) begin
      n_fail++; $display("FAIL err_snoop got upd=%b resp=%b beats=%0d required 0/00010/0", gu, rsp, beats_q.size());
    end
  endtask

  task automatic test_backpressure;
    logic [511:0] line; logic [63:0] la, ua; logic gu, acr; logic [1:0] op; logic [4:0] rsp;
    int se, oe, bad;
    line = rand_line();
    run_snoop(4'b0111, {$urandom, $urandom}, 1, 1, 1, line, 3, -1, gu, op, rsp, la, ua, se, oe, acr);
    n_tests++;
    if ({gu, op, rsp} !== 8'b101_10101) begin
      n_fail++; $display("FAIL bp_resp got upd=%b op=%0d resp=%b required 1/1/10101", gu, op, rsp);
    end
    bad = 0;
    for (int i = 0; i < beats_q.size(); i++)
      if (beats_q[i] !== line[i*64 +: 64] || lasts_q[i] !== (i == 7)) bad++;
    n_tests++;
    if (beats_q.size() != 8 || bad != 0 || se != 0 || oe != 0) begin
      n_fail++; $display("FAIL bp_stream got beats=%0d wrong=%0d stab=%0d order=%0d required 8/0/0/0",
                         beats_q.size(), bad, se, oe);
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [511:0] line; logic [63:0] la, ua; logic gu, acr, du; logic [1:0] op, eop; logic [4:0] rsp, ersp;
    int se, oe, bad;
    run_snoop(4'b0001, {$urandom, $urandom}, 1, 1, 0, rand_line(), 0, 3, gu, op, rsp, la, ua, se, oe, acr);
    n_tests++;
    if (beats_q.size() != 3 || cd_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup got beats=%0d cd_valid=%b required 3/1", beats_q.size(), cd_valid_o);
    end
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({ac_ready_o, lkp_valid_o, upd_valid_o, cr_valid_o, cd_valid_o, cd_last_o} !== 6'b100000) begin
      n_fail++; $display("FAIL mid_async_reset got %b required 100000",
                         {ac_ready_o, lkp_valid_o, upd_valid_o, cr_valid_o, cd_valid_o, cd_last_o});
    end
    lkp_ready_i = 0; upd_ready_i = 0; cr_ready_i = 0; cd_ready_i = 0; lkp_rsp_valid_i = 0; ac_valid_i = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (ac_ready_o !== 1'b1 || cd_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_release got ac_ready=%b cd_valid=%b required 1/0", ac_ready_o, cd_valid_o);
    end
    line = rand_line(); du = 1'($urandom);
    model(4'b0000, 1, du, 1, ersp, eop);
    run_snoop(4'b0000, {$urandom, $urandom}, 1, du, 1, line, 1, -1, gu, op, rsp, la, ua, se, oe, acr);
    bad = 0;
    for (int i = 0; i < beats_q.size(); i++)
      if (beats_q[i] !== line[i*64 +: 64] || lasts_q[i] !== (i == 7)) bad++;
    n_tests++;
    if (rsp !== ersp || gu !== 1'b0 || beats_q.size() != 8 || bad != 0) begin
      n_fail++; $display("FAIL mid_new_burst got resp=%b upd=%b beats=%0d wrong=%0d required %b/0/8/0",
                         rsp, gu, beats_q.size(), bad, ersp);
    end
  endtask

  task automatic test_random;
    logic [3:0] codes [8];
    logic [3:0] s; logic h, d, u, gu, acr; logic [511:0] line; logic [63:0] la, ua;
    logic [1:0] op, eop; logic [4:0] rsp, ersp; int se, oe, bad, enb, sel;
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      s = (sel < 8) ? codes[sel] : 4'($urandom);
      h = ($urandom_range(0, 3) != 0); d = 1'($urandom); u = 1'($urandom);
      line = rand_line();
      model(s, h, d, u, ersp, eop);
      enb = ersp[0] ? 8 : 0;
      run_snoop(s, {$urandom, $urandom}, h, d, u, line, $urandom_range(0, 3), -1,
                gu, op, rsp, la, ua, se, oe, acr);
      n_tests++;
      if (rsp !== ersp || {gu, op} !== {eop != 2'd0, eop}) begin
        n_fail++; $display("FAIL rnd%0d_resp s=%b h=%b d=%b u=%b got resp=%b upd=%b op=%0d required %b/%b/%0d",
                           it, s, h, d, u, rsp, gu, op, ersp, eop != 2'd0, eop);
      end
      bad = 0;
      for (int i = 0; i < beats_q.size(); i++)
        if (beats_q[i] !== line[i*64 +: 64] || lasts_q[i] !== (i == 7)) bad++;
      n_tests++;
      if (beats_q.size() != enb || bad != 0 || se != 0 || oe != 0 || acr !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_stream got beats=%0d wrong=%0d stab=%0d order=%0d ac_ready=%b required %0d/0/0/0/1",
                           it, beats_q.size(), bad, se, oe, acr, enb);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    ac_valid_i = 0; ac_addr_i = 0; ac_snoop_i = 0; ac_prot_i = 0;
    cr_ready_i = 0; cd_ready_i = 0; lkp_ready_i = 0; lkp_rsp_valid_i = 0;
    lkp_hit_i = 0; lkp_dirty_i = 0; lkp_unique_i = 0; lkp_data_i = 0; upd_ready_i = 0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1;
    @(negedge clk);
    test_read_shared;
    test_read_unique_miss;
    test_clean_invalid;
    test_error_snoop;
    test_backpressure;
    test_reset_mid_burst;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
